dmem_bytelane: RTL and testbench
================================

# dmem_bytelane

Parametrised data memory for the MIPS core, the successor to the fixed 128-word data RAM. It adds configurable depth, byte and halfword stores and loads with big-endian lane selection, sign or zero extension on loads, and misalignment detection. It also adds a req/ready handshake with a configurable number of wait states, so the pipeline's memory-stall logic can be exercised. It sits between the MEM stage and the register-file writeback path.

## Interface
- `ADDR_W`, default 9: byte-address width. Depth is 2^(ADDR_W-2) 32-bit words.
- `WAIT_CYCLES`, default 1: wait states inserted before each access. Legal range is 0..15.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in 1: access request. Sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sign` in 1: load extension. 1 = sign-extend, 0 = zero-extend. Ignored on stores.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rdata` out 32: load result, extended to 32 bits. Registered.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: misaligned or illegal access. Valid only when `ready` = 1.

## Operation
- **Reset values:** state = IDLE, `ready` = 0, `err` = 0, `rdata` = 0, wait counter = 0.
- **Memory contents:** zero-initialised at time 0 only. Not cleared by `rst`.
- **IDLE:**
  - On `req` = 1, latch `we`, `size`, `sign`, `addr`, `wdata`.
  - Misaligned or illegal access → DONE with `err` = 1. Memory is not written. Misaligned means: `size` = 01 with `addr[0]` = 1; `size` = 10 with `addr[1:0]` ≠ 0; any `size` = 11.
  - Aligned and `WAIT_CYCLES` = 0 → perform the access on this edge, then go to DONE.
  - Aligned and `WAIT_CYCLES` > 0 → counter ← `WAIT_CYCLES`−1, go to WAIT.
- **WAIT:**
  - Counter = 0 → perform the access, go to DONE.
  - Otherwise decrement the counter.
  - `req` is ignored in this state.
- **DONE:**
  - `ready` = 1 for exactly one cycle, then go to IDLE.
  - `req` is ignored in DONE. A request still high after DONE is re-accepted in IDLE. The CPU must drop `req` in the cycle after it sees `ready`.
- **Perform access:**
  - Word index is `addr[ADDR_W-1:2]`.
  - Lanes are big-endian: `addr[1:0]` = 0 selects bits [31:24]. A half at `addr[1]` = 0 selects [31:16].
  - Store: write only the selected lanes; unselected lanes keep their old contents.
  - Load: `rdata` ← selected lane(s), extended per `sign`.
  - A store leaves `rdata` = 0.
  - An `err` response sets `rdata` = 0.
- **Reset mid-operation:** an access in WAIT is abandoned. No write occurs and no `ready` is produced.

## Timing
- Request sampled at edge E0. `ready` is high in the cycle following edge E0+`WAIT_CYCLES`.
- Load latency is `WAIT_CYCLES`+1 cycles from `req`.
- Throughput is one access per `WAIT_CYCLES`+2 cycles.
- An error completes with latency 1, regardless of `WAIT_CYCLES`.
- `rdata` and `err` are stable during the `ready` cycle. They hold their value until the next completion.
- A store is visible to a load accepted at any later IDLE. No forwarding path is required.

## Structure
- Package `dmem_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state encoding IDLE/WAIT/DONE;
  - the `WAIT_CYCLES` counter width (4).
- Sub-module `dmem_lane_align` is purely combinational. It produces:
  - the store byte-enable mask and the lane-replicated write data;
  - load lane extraction and extension;
  - the misalignment flag.
- The top level holds the FSM, the counter, the request latches and the memory array.

## Test plan
- Word store then load, `WAIT_CYCLES` = 1:
  - stimulus: store 0x12345678 at addr 0x10, then load word at 0x10;
  - required: `rdata` = 0x12345678; `ready` exactly 2 cycles after each `req`.
- Byte merge with extension:
  - stimulus: store byte 0xA5 at 0x11 over word 0x12345678, then load byte at 0x11;
  - required: signed load gives 0xFFFFFFA5; unsigned load gives 0x000000A5; word at 0x10 reads 0x12A55678.
- Halfword:
  - stimulus: store half 0x8001 at 0x22, then signed load half at 0x22;
  - required: `rdata` = 0xFFFF8001; word at 0x20 has [31:16] unchanged.
- Misalignment:
  - stimulus: word load at 0x13, then half store at 0x21, then `size` = 11;
  - required: each gives `err` = 1 with latency 1, `rdata` = 0; memory at 0x20 is unchanged.
- `WAIT_CYCLES` = 0 and `WAIT_CYCLES` = 3 builds:
  - stimulus: hold `req` high for 10 cycles;
  - required: `ready` pulses every 2 and every 5 cycles respectively, never two cycles in a row.
- Reset mid-WAIT:
  - stimulus: `WAIT_CYCLES` = 3; store 0xDEADBEEF at 0x30; assert `rst` in the 2nd WAIT cycle; then load at 0x30;
  - required: no `ready` for the store; the load returns the prior contents (0).

Source files
------------

// File: rtl/dmem_bytelane_pkg.sv
// dmem_pkg: shared definitions for the byte-lane data memory.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 is illegal)
//   - FSM state encoding (IDLE / WAIT / DONE)
//   - width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for big-endian byte/half/word
// accesses to a 32-bit memory word.
// Ports:
//   size, sign, addr_lo : access descriptor (addr_lo = byte offset in word)
//   wdata               : right-justified store data
//   rword               : current contents of the addressed memory word
//   be                  : store byte enables, be[3] = bits [31:24]
//   wdata_rep           : store data replicated onto every lane
//   load_val            : extracted and extended load result
//   misaligned          : misaligned or illegal-size access
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    load_val   = '0;
    misaligned = 1'b0;

    // Big-endian: offset 0 is the most significant byte of the word.
    byte_sel = rword[31:24];
    case (addr_lo)
      2'd0:    byte_sel = rword[31:24];
      2'd1:    byte_sel = rword[23:16];
      2'd2:    byte_sel = rword[15:8];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = addr_lo[1] ? rword[15:0] : rword[31:16];

    case (size)
      SZ_BYTE: begin
        be        = 4'b1000 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_val  = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep  = {2{wdata[15:0]}};
        load_val   = {{16{sign & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        load_val   = rword;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: parametrised data memory with byte/half/word access,
// big-endian lanes, load extension, misalignment detection and a req/ready
// handshake with WAIT_CYCLES wait states.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req, we, size, sign : request and access descriptor (sampled in IDLE)
//   addr, wdata         : byte address and right-justified store data
//   rdata, ready, err   : registered load result, one-cycle completion pulse,
//                         error flag (meaningful while ready = 1)
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               sign_q, sign_d;
  logic [1:0]         size_q, size_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  // Contents start at zero and are deliberately untouched by rst.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  // The access descriptor comes straight from the inputs while in IDLE
  // (zero-wait access happens on the accepting edge), otherwise from the
  // latched copy.
  logic              acc_we, acc_sign;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       load_val;
  logic              misaligned;
  logic              do_access;
  logic              mem_we;

  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = we;
      acc_sign  = sign;
      acc_size  = size;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_we    = we_q;
      acc_sign  = sign_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign rword = mem_q[acc_addr[ADDR_W-1:2]];

  dmem_lane_align u_align (
    .size       (acc_size),
    .sign       (acc_sign),
    .addr_lo    (acc_addr[1:0]),
    .wdata      (acc_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .load_val   (load_val),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    sign_d    = sign_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          sign_d  = sign;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          if (misaligned) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_DONE;
          end else if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_access) begin
      err_d   = 1'b0;
      rdata_d = acc_we ? 32'd0 : load_val;
    end

    // ready is high exactly while the FSM sits in DONE.
    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // rst also gates the write so a zero-wait request seen during reset
  // cannot modify memory.
  assign mem_we = do_access & acc_we & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[acc_addr[ADDR_W-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: self-checking bench for dmem_bytelane.
// Three instances: index 0 with WAIT_CYCLES=1, index 1 with 0, index 2 with 3.
module tb_dmem_bytelane;

  localparam int N = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [N];
  logic        req   [N];
  logic        we    [N];
  logic [1:0]  size  [N];
  logic        sign  [N];
  logic [8:0]  addr  [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        ready [N];
  logic        err   [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
      dmem_bytelane #(.ADDR_W(9), .WAIT_CYCLES(WC)) u_dut (
        .clk   (clk),
        .rst   (rst[gi]),
        .req   (req[gi]),
        .we    (we[gi]),
        .size  (size[gi]),
        .sign  (sign[gi]),
        .addr  (addr[gi]),
        .wdata (wdata[gi]),
        .rdata (rdata[gi]),
        .ready (ready[gi]),
        .err   (err[gi])
      );
    end
  endgenerate

  function automatic int wc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: one array of words per instance, accessed by byte
  // offset arithmetic (first byte of a big-endian field sits at the top).
  bit [31:0] ref_mem [N][128];

  function automatic void model(input int d, input bit w, input bit [1:0] sz, input bit sg,
                                input bit [8:0] a, input bit [31:0] wd,
                                output bit [31:0] rd, output bit e);
    int off, idx, nbytes, shift;
    bit [31:0] word, mask;
    off = int'(a) % 4;
    idx = int'(a) / 4;
    word = ref_mem[d][idx];
    rd = 32'd0;
    e = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    if (e) return;
    nbytes = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    shift  = 8 * (4 - off - nbytes);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (w) begin
      ref_mem[d][idx] = (word & ~(mask << shift)) | ((wd & mask) << shift);
    end else begin
      rd = (word >> shift) & mask;
      if (sg && nbytes < 4 && rd[8*nbytes-1]) rd = rd | ~mask;
    end
  endfunction

  // One request/response transaction, with bounded wait for ready.
  task automatic access(input int d, input bit w, input bit [1:0] sz, input bit sg,
                        input bit [8:0] a, input bit [31:0] wd,
                        output bit [31:0] rd, output bit e, output int lat);
    bit seen;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; sign[d] = sg; addr[d] = a; wdata[d] = wd;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      req[d] = 1'b0;
      seen = ready[d];
    end
    chk("ready_seen", 32'(seen), 32'd1);
    rd = rdata[d];
    e  = err[d];
    $display("dut%0d %s size=%0d sign=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             d, w ? "ST" : "LD", sz, sg, a, wd, rd, e, lat);
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready[d]), 32'd0);
  endtask

  typedef struct {
    bit        w;
    bit [1:0]  sz;
    bit        sg;
    bit [8:0]  a;
    bit [31:0] wd;
    bit [31:0] exp_rd;
    bit        exp_e;
    int        exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input bit w, input bit [1:0] sz, input bit sg, input bit [8:0] a,
                               input bit [31:0] wd, input bit [31:0] exp_rd, input bit exp_e);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_e = exp_e; v.exp_lat = exp_e ? 1 : 2;
    vecs.push_back(v);
  endfunction

  // Hold req high with word loads at 0 and check pulse spacing.
  task automatic burst(input int d);
    int wc, prev, npulse;
    bit last;
    wc = wc_of(d); prev = -1; npulse = 0; last = 1'b0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b0; size[d] = 2'd2; sign[d] = 1'b0; addr[d] = 9'd0; wdata[d] = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready[d]) begin
        chk("burst_no_back_to_back", 32'(last), 32'd0);
        if (prev < 0) chk("burst_first_latency", 32'(i), 32'(wc + 1));
        else          chk("burst_period", 32'(i - prev), 32'(wc + 2));
        prev = i;
        npulse++;
      end
      last = ready[d];
    end
    req[d] = 1'b0;
    chk("burst_pulse_count", 32'(npulse), 32'((20 - (wc + 1)) / (wc + 2) + 1));
    $display("dut%0d burst wait=%0d pulses=%0d", d, wc, npulse);
    repeat (wc + 3) @(negedge clk);
  endtask

  task automatic rand_run(input int d, input int count);
    bit [31:0] rd, mrd, wd;
    bit e, me, w, sg;
    bit [1:0] sz;
    bit [8:0] a;
    int lat;
    for (int k = 0; k < count; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 9'($urandom_range(0, 511));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a = a & 9'h1FC;
        else if (sz == 2'd1) a = a & 9'h1FE;
      end
      model(d, w, sz, sg, a, wd, mrd, me);
      access(d, w, sz, sg, a, wd, rd, e, lat);
      chk("rand_rdata", rd, mrd);
      chk("rand_err", 32'(e), 32'(me));
      chk("rand_latency", 32'(lat), 32'(me ? 1 : wc_of(d) + 1));
      chk("rand_rdata_hold", rdata[d], mrd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] rd, mrd;
    bit e, me;
    int lat;

    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0;
      sign[d] = 1'b0; addr[d] = 9'd0; wdata[d] = 32'd0;
    end

    // Directed vectors for the WAIT_CYCLES=1 instance.
    addv(1, 2'd2, 0, 9'h010, 32'h1234_5678, 32'h0000_0000, 0);
    addv(0, 2'd2, 0, 9'h010, 32'h0,         32'h1234_5678, 0);
    addv(1, 2'd0, 0, 9'h011, 32'h5A5A_5AA5, 32'h0000_0000, 0);
    addv(0, 2'd0, 1, 9'h011, 32'h0,         32'hFFFF_FFA5, 0);
    addv(0, 2'd0, 0, 9'h011, 32'h0,         32'h0000_00A5, 0);
    addv(0, 2'd2, 0, 9'h010, 32'h0,         32'h12A5_5678, 0);
    addv(0, 2'd0, 0, 9'h010, 32'h0,         32'h0000_0012, 0);
    addv(0, 2'd0, 1, 9'h013, 32'h0,         32'h0000_0078, 0);
    addv(1, 2'd2, 0, 9'h020, 32'hCAFE_BABE, 32'h0000_0000, 0);
    addv(1, 2'd1, 0, 9'h022, 32'h1234_8001, 32'h0000_0000, 0);
    addv(0, 2'd1, 1, 9'h022, 32'h0,         32'hFFFF_8001, 0);
    addv(0, 2'd1, 0, 9'h022, 32'h0,         32'h0000_8001, 0);
    addv(0, 2'd1, 1, 9'h020, 32'h0,         32'hFFFF_CAFE, 0);
    addv(0, 2'd2, 0, 9'h020, 32'h0,         32'hCAFE_8001, 0);
    addv(0, 2'd2, 0, 9'h013, 32'h0,         32'h0000_0000, 1);
    addv(1, 2'd1, 0, 9'h021, 32'h0000_FFFF, 32'h0000_0000, 1);
    addv(0, 2'd3, 0, 9'h020, 32'h0,         32'h0000_0000, 1);
    addv(1, 2'd3, 0, 9'h020, 32'h0000_0001, 32'h0000_0000, 1);
    addv(0, 2'd2, 0, 9'h020, 32'h0,         32'hCAFE_8001, 0);

    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk("reset_ready", 32'(ready[d]), 32'd0);
      chk("reset_err",   32'(err[d]),   32'd0);
      chk("reset_rdata", rdata[d],      32'd0);
      rst[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("post_reset_idle_ready", 32'(ready[0]), 32'd0);

    foreach (vecs[i]) begin
      model(0, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, mrd, me);
      access(0, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_e));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata_hold", i), rdata[0], vecs[i].exp_rd);
    end

    rand_run(0, 300);

    burst(1);
    burst(2);

    // Reset in the second WAIT cycle of a store on the WAIT_CYCLES=3 instance.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'd2; sign[2] = 1'b0; addr[2] = 9'h030; wdata[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    req[2] = 1'b0;
    chk("abort_wait1_ready", 32'(ready[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("abort_in_reset_ready", 32'(ready[2]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_held_ready", 32'(ready[2]), 32'd0);
    end
    rst[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(ready[2]), 32'd0);
    end
    $display("dut2 store 0x30 abandoned by reset");
    access(2, 1'b0, 2'd2, 1'b0, 9'h030, 32'd0, rd, e, lat);
    chk("abort_load_rdata", rd, 32'd0);
    chk("abort_load_err", 32'(e), 32'd0);
    chk("abort_load_latency", 32'(lat), 32'd4);

    rand_run(1, 60);
    rand_run(2, 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
